alu_ctrl_fsm: RTL and testbench
===============================

// Module: alu_ctrl_fsm
// PURPOSE
//  Multi-cycle control sequencer for the semi_cpu datapath. It is the producer side of the ALU op interface.
//  It fetches a 32-bit instruction over a req/valid handshake and decodes it. It then drives alu_op,
//  register addresses, the immediate and the operand select, and pulses the register-file write enable.
//  The PC and a retired-instruction counter are kept here; the ALU and register file stay outside.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  PC_STEP    4              PC increment per retired/skipped instruction
//  ZERO_REG   1              1: writes to rd==0 suppressed (rf_we held low)
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   asynchronous, active-high reset
//  imem_req     out  1   fetch request, high exactly one cycle per fetch
//  imem_addr    out  32  fetch address (= pc)
//  imem_valid   in   1   instruction data valid
//  imem_rdata   in   32  instruction word
//  stall        in   1   datapath not ready; holds EXECUTE
//  alu_op       out  3   ALU operation code
//  rs1_addr     out  5   operand1 register index
//  rs2_addr     out  5   operand2 register index
//  rd_addr      out  5   destination register index
//  use_imm      out  1   1: operand2 = imm_ext, 0: operand2 = reg[rs2]
//  imm_ext      out  32  zero-extended imm14
//  rf_we        out  1   register-file write strobe, one cycle per writing instruction
//  pc           out  32  current program counter
//  halted       out  1   high while in HALT
//  retired_cnt  out  32  count of instructions that asserted rf_we (wraps at 2^32)
// BEHAVIOUR
//  Instruction fields: op=[31:29] rd=[28:24] rs1=[23:19] rs2=[18:14] imm14=[13:0].
//   op 000 NOP, 001 HALT.
//   op 010 ADD, 011 SUB, 100 SHL, 101 SHR (use_imm=0).
//   op 110 ADDI, 111 SUBI (use_imm=1).
//   alu_op = op for 010..111.
//  Reset (async, any state): state=FETCH, pc=RESET_PC, instr reg=0, retired_cnt=0.
//   All other outputs are 0, including alu_op=000, so the ALU result is 0.
//  States and transitions:
//   FETCH:  imem_req=1, imem_addr=pc -> WAIT.
//   WAIT:   imem_req=0. If imem_valid=1, latch imem_rdata -> DECODE; otherwise stay in WAIT.
//           imem_valid is sampled only in WAIT and ignored in every other state.
//   DECODE: drive rs1/rs2/rd/use_imm/imm_ext from the latched word. Then:
//           NOP  -> pc+=PC_STEP, go to FETCH.
//           HALT -> go to HALT; pc unchanged.
//           else -> EXECUTE.
//   EXECUTE: alu_op valid. If stall=1, stay with all outputs held; otherwise -> WRITEBACK.
//   WRITEBACK: rf_we=1 for this single cycle (0 if ZERO_REG and rd==0); alu_op still valid.
//           retired_cnt increments only when rf_we=1. Then pc+=PC_STEP, go to FETCH.
//   HALT:   halted=1, all strobes 0. Sticky until rst.
//  Output timing:
//   alu_op is 000 outside EXECUTE/WRITEBACK.
//   Decode fields hold from DECODE until the next DECODE.
//  Latency: with 1-cycle imem, ALU ops take 5 cycles (F,W,D,E,WB) and NOP takes 3.
//  pc wraps modulo 2^32 with no flag.
//  A stall asserted in any state other than EXECUTE is ignored.
// TESTING
//  rst=1 mid-EXECUTE -> next edge: alu_op=0, rf_we=0, pc=RESET_PC, imem_req=0;
//    first imem_req is seen 1 cycle after rst falls.
//  ADD r3,r1,r2 (32'h4308_8000), imem_valid one cycle later -> alu_op=010, rs1=1, rs2=2, rd=3, use_imm=0;
//    rf_we high exactly 1 cycle, 4 cycles after imem_req; pc=4; retired_cnt=1.
//  ADDI r5,r1,#0x3FFF -> use_imm=1, imm_ext=32'h0000_3FFF, alu_op=110.
//  SUB to rd=0 with ZERO_REG=1 -> alu_op=011 in E/WB, rf_we stays 0, retired_cnt unchanged, pc+=4.
//  stall=1 for 3 cycles in EXECUTE -> outputs frozen; rf_we asserts 1 cycle after stall falls, exactly once.
//  Sequence:
//   NOP (32'h0) -> no rf_we, pc advances by 4 within 3 cycles.
//   HALT (32'h2000_0000) -> halted=1, no further imem_req for 20 cycles.
//   imem_valid pulses while halted -> ignored.

Source files
------------

// File: rtl/alu_ctrl_if.sv
// Sequencer-side bundle: instruction fetch handshake plus ALU/register-file control and status.
interface alu_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [2:0]  alu_op;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic        use_imm;
  logic [31:0] imm_ext;
  logic        rf_we;
  logic [31:0] pc;
  logic        halted;
  logic [31:0] retired_cnt;

  modport master (
    output imem_req, imem_addr, alu_op, rs1_addr, rs2_addr, rd_addr,
           use_imm, imm_ext, rf_we, pc, halted, retired_cnt,
    input  imem_valid, imem_rdata, stall
  );

  modport slave (
    input  imem_req, imem_addr, alu_op, rs1_addr, rs2_addr, rd_addr,
           use_imm, imm_ext, rf_we, pc, halted, retired_cnt,
    output imem_valid, imem_rdata, stall
  );
endinterface

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the semi_cpu datapath.
// ALU ops take 5 cycles with a 1-cycle imem (NOP 3); stall holds EXECUTE, imem_valid waits in WAIT.
module alu_ctrl_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic        clk,
  input logic        rst,
  alu_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_WAIT, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [2:0]  OP_NOP  = 3'b000;
  localparam logic [2:0]  OP_HALT = 3'b001;
  localparam logic [31:0] PC_INC  = 32'(PC_STEP);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] retired_q;
  logic [2:0]  alu_op_q;
  logic        req_q;
  logic        we_q;
  logic        halted_q;

  logic [2:0]  op_w;
  logic [4:0]  rd_w;

  assign op_w = instr_q[31:29];
  assign rd_w = instr_q[28:24];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      alu_op_q  <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      req_q <= 1'b0;
      we_q  <= 1'b0;
      case (state_q)
        // Out of reset FETCH spends one idle cycle raising the request; later entries arrive with it set.
        S_FETCH: begin
          if (req_q) state_q <= S_WAIT;
          else       req_q   <= 1'b1;
        end
        S_WAIT: begin
          if (bus.imem_valid) begin
            instr_q <= bus.imem_rdata;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (op_w)
            OP_NOP: begin
              pc_q    <= pc_q + PC_INC;
              req_q   <= 1'b1;
              state_q <= S_FETCH;
            end
            OP_HALT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            default: begin
              alu_op_q <= op_w;
              state_q  <= S_EXECUTE;
            end
          endcase
        end
        S_EXECUTE: begin
          if (!bus.stall) begin
            we_q    <= !(ZERO_REG && (rd_w == 5'd0));
            state_q <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          alu_op_q <= '0;
          if (we_q) retired_q <= retired_q + 32'd1;
          pc_q    <= pc_q + PC_INC;
          req_q   <= 1'b1;
          state_q <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Decode fields come straight from the latched word so they hold until the next DECODE.
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.rs1_addr    = instr_q[23:19];
  assign bus.rs2_addr    = instr_q[18:14];
  assign bus.rd_addr     = rd_w;
  assign bus.use_imm     = op_w[2] & op_w[1];
  assign bus.imm_ext     = {18'd0, instr_q[13:0]};
  assign bus.rf_we       = we_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;
  assign bus.retired_cnt = retired_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Bench for alu_ctrl_fsm: directed vector table, randomized instructions against a decode model, reset and halt sequences.
module tb_alu_ctrl_fsm;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_ctrl_if bus();
  alu_ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] ins;
    int          vdelay;
    int          nstall;
    logic [2:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        imm_sel;
    logic [31:0] imm;
    logic        we;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  int exp_req_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic vec_t mk(input logic [31:0] ins, input int vd, input int ns,
                              input logic [2:0] alu, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic ui, input logic [31:0] imm, input logic we);
    vec_t v;
    v.ins = ins; v.vdelay = vd; v.nstall = ns; v.alu = alu; v.rs1 = rs1; v.rs2 = rs2;
    v.rd = rd; v.imm_sel = ui; v.imm = imm; v.we = we;
    return v;
  endfunction

  // Reference decode: plain field arithmetic on the instruction word.
  function automatic vec_t model(input logic [31:0] ins, input int vd, input int ns);
    int op, rd;
    op = int'(ins / 32'h2000_0000);
    rd = int'((ins / 32'h0100_0000) % 32);
    return mk(ins, vd, ns, (op >= 2) ? 3'(op) : 3'd0, 5'((ins / 32'h8_0000) % 32),
              5'((ins / 32'h4000) % 32), 5'(rd), op >= 6, ins % 32'h4000, (op >= 2) && (rd != 0));
  endfunction

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.imem_req) begin
        got = 1'b1;
        break;
      end
      if (bus.rf_we) chk("stray_rf_we", 32'(bus.rf_we), 0);
    end
    if (!got) chk("req_timeout", 0, 1);
  endtask

  task automatic fetch_check(output int t_req, output bit got);
    wait_req(got);
    t_req = cyc;
    if (got) begin
      if (exp_req_cyc >= 0) chk("req_latency", t_req, exp_req_cyc);
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("retired_cnt", bus.retired_cnt, m_ret);
      chk("alu_op_fetch", 32'(bus.alu_op), 0);
    end
  endtask

  // Feeds one instruction through the DUT; the caller is left in DECODE of that instruction.
  task automatic deliver(input logic [31:0] ins, input int vdelay);
    @(posedge clk); #1;
    chk("req_one_cycle", 32'(bus.imem_req), 0);
    repeat (vdelay) begin
      bus.imem_valid = 1'b0;
      bus.imem_rdata = $urandom;
      @(posedge clk); #1;
    end
    bus.imem_valid = 1'b1;
    bus.imem_rdata = ins;
    @(posedge clk); #1;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = $urandom;
  endtask

  task automatic run_instr(input vec_t v);
    int t_req, t_d;
    bit got;
    fetch_check(t_req, got);
    if (!got) return;
    deliver(v.ins, v.vdelay);
    t_d = cyc;
    bus.stall = (v.nstall > 0);
    @(negedge clk);
    chk("rs1_addr", 32'(bus.rs1_addr), 32'(v.rs1));
    chk("rs2_addr", 32'(bus.rs2_addr), 32'(v.rs2));
    chk("rd_addr", 32'(bus.rd_addr), 32'(v.rd));
    chk("use_imm", 32'(bus.use_imm), 32'(v.imm_sel));
    chk("imm_ext", bus.imm_ext, v.imm);
    chk("alu_op_decode", 32'(bus.alu_op), 0);
    if (v.ins[31:29] == 3'b000) begin
      m_pc += 32'd4;
      exp_req_cyc = t_d + 1;
      bus.stall = 1'b0;
      return;
    end
    for (int k = 0; k <= v.nstall; k++) begin
      @(posedge clk); #1;
      bus.stall = (k < v.nstall);
      bus.imem_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("alu_op_exec", 32'(bus.alu_op), 32'(v.alu));
      chk("rf_we_exec", 32'(bus.rf_we), 0);
      chk("rd_held", 32'(bus.rd_addr), 32'(v.rd));
    end
    @(posedge clk); #1;
    bus.stall = 1'($urandom_range(0, 1));
    bus.imem_valid = 1'b0;
    @(negedge clk);
    chk("rf_we_wb", 32'(bus.rf_we), 32'(v.we));
    chk("alu_op_wb", 32'(bus.alu_op), 32'(v.alu));
    chk("wb_latency", cyc - t_req, 4 + v.vdelay + v.nstall);
    if (v.we) m_ret += 32'd1;
    m_pc += 32'd4;
    exp_req_cyc = cyc + 1;
    @(posedge clk); #1;
    bus.stall = 1'b0;
  endtask

  task automatic reset_checks();
    chk("rst_imem_req", 32'(bus.imem_req), 0);
    chk("rst_pc", bus.pc, 0);
    chk("rst_alu_op", 32'(bus.alu_op), 0);
    chk("rst_rf_we", 32'(bus.rf_we), 0);
    chk("rst_retired", bus.retired_cnt, 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = 32'h0;
    m_ret = 32'h0;
    @(negedge clk);
    chk("req_low_after_rst", 32'(bus.imem_req), 0);
    exp_req_cyc = cyc + 1;
  endtask

  vec_t tbl[9];
  vec_t rv;
  bit   got;
  int   t_req;
  logic [2:0] rop;

  initial begin
    rst = 1'b1;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.stall = 1'b0;
    m_pc = 32'h0;
    m_ret = 32'h0;
    tbl[0] = mk(32'h4308_8000, 0, 0, 3'b010, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b1);
    tbl[1] = mk(32'hC508_3FFF, 0, 0, 3'b110, 5'd1, 5'd0, 5'd5, 1'b1, 32'h3FFF, 1'b1);
    tbl[2] = mk(32'h6021_4000, 0, 0, 3'b011, 5'd4, 5'd5, 5'd0, 1'b0, 32'h0, 1'b0);
    tbl[3] = mk(32'h8710_C155, 0, 3, 3'b100, 5'd2, 5'd3, 5'd7, 1'b0, 32'h155, 1'b1);
    tbl[4] = mk(32'hBFFF_C000, 2, 1, 3'b101, 5'd31, 5'd31, 5'd31, 1'b0, 32'h0, 1'b1);
    tbl[5] = mk(32'hE100_0001, 1, 0, 3'b111, 5'd0, 5'd0, 5'd1, 1'b1, 32'h1, 1'b1);
    tbl[6] = mk(32'h0000_0000, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0);
    tbl[7] = mk(32'h1F00_1234, 3, 0, 3'b000, 5'd0, 5'd0, 5'd31, 1'b0, 32'h1234, 1'b0);
    tbl[8] = mk(32'hC000_0005, 0, 2, 3'b110, 5'd0, 5'd0, 5'd0, 1'b1, 32'h5, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks();
    release_reset();

    foreach (tbl[i]) run_instr(tbl[i]);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 6));
      if (rop != 3'd0) rop = rop + 3'd1;
      rv = model({rop, 29'($urandom)}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run_instr(rv);
    end

    // Reset in the middle of a stalled EXECUTE.
    fetch_check(t_req, got);
    deliver(32'h4308_8000, 0);
    bus.stall = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    reset_checks();
    bus.stall = 1'b0;
    @(negedge clk);
    chk("rst_hold_alu_op", 32'(bus.alu_op), 0);
    release_reset();
    run_instr(tbl[0]);

    // HALT is sticky and ignores imem_valid.
    fetch_check(t_req, got);
    deliver(32'h2000_0000, 0);
    @(negedge clk);
    chk("halted_decode", 32'(bus.halted), 0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      bus.imem_valid = 1'($urandom_range(0, 1));
      bus.imem_rdata = 32'h4308_8000;
      bus.stall = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halted", 32'(bus.halted), 1);
      chk("halt_no_req", 32'(bus.imem_req), 0);
      chk("halt_no_we", 32'(bus.rf_we), 0);
      chk("halt_pc", bus.pc, m_pc);
    end
    chk("halt_retired", bus.retired_cnt, m_ret);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
